// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, protection bits and helpers for the APB manager
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mgr_state_e;

  localparam logic [2:0] PROT_PRIV   = 3'b001;
  localparam logic [2:0] PROT_NONSEC = 3'b010;
  localparam logic [2:0] PROT_INSTR  = 3'b100;

  // A single peripheral still keeps one index bit so stray addresses decode as errors.
  function automatic int calc_idx_width(input int prph_num);
    return (prph_num <= 2) ? 1 : $clog2(prph_num);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational region decoder: index, one-hot select, decode error
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int AddrWidth  = 32,
  parameter int PrphNum    = 4,
  parameter int RegionBits = 12,
  localparam int IdxW      = calc_idx_width(PrphNum)
) (
  input  logic [AddrWidth-1:0] addr,
  output logic [IdxW-1:0]      index,
  output logic [PrphNum-1:0]   selectors,
  output logic                 decodeErr
);

  logic unused_addr_bits;

  assign index            = addr[RegionBits +: IdxW];
  assign unused_addr_bits = ^addr;

  always_comb begin
    decodeErr = (int'(index) >= PrphNum);
    selectors = '0;
    for (int i = 0; i < PrphNum; i++) begin
      selectors[i] = !decodeErr && (int'(index) == i);
    end
  end

endmodule

// File: rtl/apb_multi_manager.sv
// rtl/apb_multi_manager.sv - valid/ready to APB requester with decode, wait-state timeout and held response
module apb_multi_manager
  import apb_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int PrphNum       = 4,
  parameter int RegionBits    = 12,
  parameter int TimeoutCycles = 16
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic                           reqWrite,
  input  logic [AddrWidth-1:0]           reqAddr,
  input  logic [DataWidth-1:0]           reqWData,
  input  logic [DataWidth/8-1:0]         reqStrb,
  input  logic [2:0]                     reqProt,
  output logic                           rspValid,
  input  logic                           rspReady,
  output logic [DataWidth-1:0]           rspRData,
  output logic                           rspError,
  output logic [AddrWidth-1:0]           addr,
  output logic [2:0]                     prot,
  output logic [PrphNum-1:0]             selectors,
  output logic                           enable,
  output logic                           write,
  output logic [DataWidth-1:0]           wData,
  output logic [DataWidth/8-1:0]         strb,
  input  logic [PrphNum-1:0]             prphReady,
  input  logic [PrphNum*DataWidth-1:0]   prphRData,
  input  logic [PrphNum-1:0]             prphError
);

  localparam int IdxW = calc_idx_width(PrphNum);
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  apb_mgr_state_e state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [2:0]             prot_q, prot_d;
  logic [PrphNum-1:0]     sel_q, sel_d;
  logic                   enable_q, enable_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] strb_q, strb_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [IdxW-1:0]        unused_dec_index;
  logic [PrphNum-1:0]     dec_sel;
  logic                   dec_err;
  logic                   sel_ready;
  logic                   sel_error;
  logic [DataWidth-1:0]   lane_rdata;
  logic                   timeout_hit;

  apb_addr_decoder #(
    .AddrWidth (AddrWidth),
    .PrphNum   (PrphNum),
    .RegionBits(RegionBits)
  ) u_decoder (
    .addr     (reqAddr),
    .index    (unused_dec_index),
    .selectors(dec_sel),
    .decodeErr(dec_err)
  );

  // The registered one-hot select doubles as the lane mask, so unselected lanes never leak through.
  always_comb begin
    lane_rdata = '0;
    for (int i = 0; i < PrphNum; i++) begin
      if (sel_q[i]) lane_rdata |= prphRData[i*DataWidth +: DataWidth];
    end
    sel_ready   = |(prphReady & sel_q);
    sel_error   = |(prphError & sel_q);
    timeout_hit = (TimeoutCycles > 0) && (cnt_q == CntLast);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    prot_d   = prot_q;
    sel_d    = sel_q;
    enable_d = enable_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d  = reqAddr;
          prot_d  = reqProt;
          write_d = reqWrite;
          wdata_d = reqWData;
          strb_d  = reqWrite ? reqStrb : '0;
          if (dec_err) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = SETUP;
            sel_d   = dec_sel;
            cnt_d   = '0;
          end
        end
      end
      SETUP: begin
        enable_d = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d  = (!write_q && !sel_error) ? lane_rdata : '0;
          err_d    = sel_error;
          sel_d    = '0;
          enable_d = 1'b0;
          state_d  = RESP;
        end else if (timeout_hit) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          sel_d    = '0;
          enable_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      prot_q   <= '0;
      sel_q    <= '0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      prot_q   <= prot_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign reqReady  = (state_q == IDLE);
  assign rspValid  = (state_q == RESP);
  assign rspRData  = rdata_q;
  assign rspError  = err_q;
  assign addr      = addr_q;
  assign prot      = prot_q;
  assign selectors = sel_q;
  assign enable    = enable_q;
  assign write     = write_q;
  assign wData     = wdata_q;
  assign strb      = strb_q;

endmodule

// File: tb/tb_apb_multi_manager.sv
// tb/tb_apb_multi_manager.sv - directed self-checking bench for apb_multi_manager
module tb_apb_multi_manager;
  import apb_pkg::*;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: four peripherals, 16-cycle timeout
  logic        reqValid, reqReady, reqWrite, rspValid, rspReady, rspError, enable, write;
  logic [31:0] reqAddr, reqWData, rspRData, addr, wData;
  logic [3:0]  reqStrb, strb, selectors, prphReady, prphError;
  logic [2:0]  reqProt, prot;
  logic [127:0] prphRData;

  apb_multi_manager #(.AddrWidth(32), .DataWidth(32), .PrphNum(4), .RegionBits(12), .TimeoutCycles(16)) u_dut (
    .clk(clk), .nReset(nReset), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWData(reqWData), .reqStrb(reqStrb), .reqProt(reqProt),
    .rspValid(rspValid), .rspReady(rspReady), .rspRData(rspRData), .rspError(rspError),
    .addr(addr), .prot(prot), .selectors(selectors), .enable(enable), .write(write),
    .wData(wData), .strb(strb), .prphReady(prphReady), .prphRData(prphRData), .prphError(prphError)
  );

  // Second instance: three peripherals, so index 3 is a decode error
  logic        r3_reqValid, r3_reqReady, r3_reqWrite, r3_rspValid, r3_rspReady, r3_rspError, r3_enable, r3_write;
  logic [31:0] r3_reqAddr, r3_reqWData, r3_rspRData, r3_addr, r3_wData;
  logic [3:0]  r3_reqStrb, r3_strb;
  logic [2:0]  r3_reqProt, r3_prot, r3_selectors, r3_prphReady, r3_prphError;
  logic [95:0] r3_prphRData;

  apb_multi_manager #(.AddrWidth(32), .DataWidth(32), .PrphNum(3), .RegionBits(12), .TimeoutCycles(16)) u_dut3 (
    .clk(clk), .nReset(nReset), .reqValid(r3_reqValid), .reqReady(r3_reqReady), .reqWrite(r3_reqWrite),
    .reqAddr(r3_reqAddr), .reqWData(r3_reqWData), .reqStrb(r3_reqStrb), .reqProt(r3_reqProt),
    .rspValid(r3_rspValid), .rspReady(r3_rspReady), .rspRData(r3_rspRData), .rspError(r3_rspError),
    .addr(r3_addr), .prot(r3_prot), .selectors(r3_selectors), .enable(r3_enable), .write(r3_write),
    .wData(r3_wData), .strb(r3_strb), .prphReady(r3_prphReady), .prphRData(r3_prphRData), .prphError(r3_prphError)
  );

  int act3 = 0;
  always @(negedge clk) begin
    if (r3_selectors !== 3'b000 || r3_enable !== 1'b0) act3 = act3 + 1;
  end

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWData = d; reqStrb = s; reqProt = PROT_NONSEC;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady got %b want 1", reqReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_rspValid got %b want 0", rspValid); end
    checks++; if (selectors !== 4'b0000 || enable !== 1'b0) begin errors++; $display("FAIL reset_apb got sel=%b en=%b want 0000/0", selectors, enable); end
    checks++; if ({addr, wData, strb, prot, write} !== '0) begin errors++; $display("FAIL reset_regs got addr=%h wData=%h strb=%h prot=%h write=%b want all 0", addr, wData, strb, prot, write); end
    checks++; if (rspRData !== 32'h0 || rspError !== 1'b0) begin errors++; $display("FAIL reset_rsp got rdata=%h err=%b want 0/0", rspRData, rspError); end
  endtask

  task automatic test_zero_wait_write;
    prphReady = 4'b1111; prphError = 4'b0000; rspReady = 1'b1;
    start_req(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF);
    checks++; if (selectors !== 4'b0100 || enable !== 1'b0 || reqReady !== 1'b0) begin errors++; $display("FAIL zw_setup got sel=%b en=%b rdy=%b want 0100/0/0", selectors, enable, reqReady); end
    checks++; if (addr !== 32'h2010 || wData !== 32'hDEADBEEF || strb !== 4'hF || write !== 1'b1 || prot !== PROT_NONSEC) begin errors++; $display("FAIL zw_apb_regs got addr=%h wData=%h strb=%h write=%b prot=%b", addr, wData, strb, write, prot); end
    @(negedge clk);
    checks++; if (selectors !== 4'b0100 || enable !== 1'b1 || rspValid !== 1'b0) begin errors++; $display("FAIL zw_access got sel=%b en=%b rv=%b want 0100/1/0", selectors, enable, rspValid); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b1 || rspError !== 1'b0 || rspRData !== 32'h0) begin errors++; $display("FAIL zw_resp got rv=%b err=%b rdata=%h want 1/0/0", rspValid, rspError, rspRData); end
    checks++; if (selectors !== 4'b0000 || enable !== 1'b0) begin errors++; $display("FAIL zw_resp_apb got sel=%b en=%b want 0000/0", selectors, enable); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin errors++; $display("FAIL zw_idle got rv=%b rdy=%b want 0/1", rspValid, reqReady); end
  endtask

  task automatic test_wait_read;
    int bad = 0;
    prphReady = 4'b0000; prphError = 4'b0000; rspReady = 1'b1;
    prphRData = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hAAAA_AAAA};
    start_req(1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'hF);
    checks++; if (strb !== 4'h0 || write !== 1'b0 || selectors !== 4'b0010) begin errors++; $display("FAIL wr_setup got strb=%h write=%b sel=%b want 0/0/0010", strb, write, selectors); end
    prphReady = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (enable !== 1'b1 || selectors !== 4'b0010 || addr !== 32'h1004 || strb !== 4'h0 || rspValid !== 1'b0) bad++;
    end
    prphReady = 4'b0011;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr_access_stable got %0d unstable cycles want 0", bad); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b1 || rspRData !== 32'h1234_5678 || rspError !== 1'b0) begin errors++; $display("FAIL wr_resp got rv=%b rdata=%h err=%b want 1/12345678/0", rspValid, rspRData, rspError); end
    prphReady = 4'b0000;
    @(negedge clk);
    checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin errors++; $display("FAIL wr_idle got rv=%b rdy=%b want 0/1", rspValid, reqReady); end
  endtask

  task automatic test_periph_error;
    rspReady = 1'b1;
    prphRData = {32'h55AA_55AA, 32'hCAFE_F00D, 32'h1111_1111, 32'h0000_0001};
    prphReady = 4'b0100; prphError = 4'b0001;
    start_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    checks++; if (rspValid !== 1'b1 || rspError !== 1'b0 || rspRData !== 32'hCAFE_F00D) begin errors++; $display("FAIL pe_unselected got rv=%b err=%b rdata=%h want 1/0/cafef00d", rspValid, rspError, rspRData); end
    prphReady = 4'b1000; prphError = 4'b1000;
    start_req(1'b0, 32'h0000_3008, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    checks++; if (rspValid !== 1'b1 || rspError !== 1'b1 || rspRData !== 32'h0) begin errors++; $display("FAIL pe_selected got rv=%b err=%b rdata=%h want 1/1/0", rspValid, rspError, rspRData); end
    prphReady = 4'b0000; prphError = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_decode_error;
    int a0;
    r3_rspReady = 1'b1;
    @(negedge clk);
    a0 = act3;
    r3_reqValid = 1'b1; r3_reqWrite = 1'b0; r3_reqAddr = 32'h0000_3000;
    checks++; if (r3_reqReady !== 1'b1) begin errors++; $display("FAIL de_ready got %b want 1", r3_reqReady); end
    @(posedge clk); @(negedge clk);
    r3_reqValid = 1'b0;
    checks++; if (r3_rspValid !== 1'b1 || r3_rspError !== 1'b1 || r3_rspRData !== 32'h0) begin errors++; $display("FAIL de_resp got rv=%b err=%b rdata=%h want 1/1/0", r3_rspValid, r3_rspError, r3_rspRData); end
    @(negedge clk);
    checks++; if (r3_rspValid !== 1'b0 || r3_reqReady !== 1'b1) begin errors++; $display("FAIL de_idle got rv=%b rdy=%b want 0/1", r3_rspValid, r3_reqReady); end
    @(negedge clk);
    checks++; if (act3 !== a0) begin errors++; $display("FAIL de_no_apb got %0d active cycles want 0", act3 - a0); end
    r3_reqValid = 1'b1; r3_reqAddr = 32'h0000_2004;
    @(posedge clk); @(negedge clk);
    r3_reqValid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (r3_rspValid !== 1'b1 || r3_rspError !== 1'b0 || r3_rspRData !== 32'h00C0_FFEE) begin errors++; $display("FAIL de_valid3 got rv=%b err=%b rdata=%h want 1/0/00c0ffee", r3_rspValid, r3_rspError, r3_rspRData); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    bit done;
    prphReady = 4'b0000; prphError = 4'b0000; rspReady = 1'b1;
    prphRData = {32'h0, 32'h0, 32'h0, 32'h0BAD_CAFE};
    start_req(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    n = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (enable === 1'b1) n++; else done = 1'b1;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_access_cycles got %0d want 16", n); end
    checks++; if (rspValid !== 1'b1 || rspError !== 1'b1 || rspRData !== 32'h0 || selectors !== 4'b0000 || enable !== 1'b0) begin errors++; $display("FAIL to_abort got rv=%b err=%b rdata=%h sel=%b en=%b want 1/1/0/0000/0", rspValid, rspError, rspRData, selectors, enable); end
    @(negedge clk);
    start_req(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (enable === 1'b1) n++;
    end
    prphReady = 4'b0001;
    checks++; if (n !== 16) begin errors++; $display("FAIL to_edge_cycles got %0d want 16", n); end
    @(negedge clk);
    prphReady = 4'b0000;
    checks++; if (rspValid !== 1'b1 || rspError !== 1'b0 || rspRData !== 32'h0BAD_CAFE) begin errors++; $display("FAIL to_edge_resp got rv=%b err=%b rdata=%h want 1/0/0badcafe", rspValid, rspError, rspRData); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int rsp = 0;
    prphReady = 4'b1111; rspReady = 1'b1;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h0000_0100; reqWData = 32'h1; reqStrb = 4'h3;
    for (int k = 0; k < 8; k++) begin
      if (reqReady === 1'b1) acc++;
      if (rspValid === 1'b1) rsp++;
      @(negedge clk);
    end
    reqValid = 1'b0;
    checks++; if (acc !== 2 || rsp !== 2) begin errors++; $display("FAIL b2b got accepts=%0d responses=%0d want 2/2", acc, rsp); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", reqReady); end
    prphReady = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_backpressure_reset;
    int bad = 0;
    prphReady = 4'b0010; rspReady = 1'b0;
    prphRData = {32'h0, 32'h0, 32'h1357_2468, 32'h0};
    start_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 32'h0000_2000; reqWrite = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rspValid !== 1'b1 || rspRData !== 32'h1357_2468 || rspError !== 1'b0 || reqReady !== 1'b0 || addr !== 32'h1000) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    reqValid = 1'b0; rspReady = 1'b1;
    @(negedge clk);
    checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin errors++; $display("FAIL bp_release got rv=%b rdy=%b want 0/1", rspValid, reqReady); end
    prphReady = 4'b0000;
    start_req(1'b1, 32'h0000_2040, 32'h8765_4321, 4'hC);
    @(negedge clk);
    checks++; if (enable !== 1'b1 || selectors !== 4'b0100) begin errors++; $display("FAIL rst_pre got en=%b sel=%b want 1/0100", enable, selectors); end
    #2 nReset = 1'b0;
    #1;
    checks++; if (selectors !== 4'b0000 || enable !== 1'b0 || rspValid !== 1'b0 || reqReady !== 1'b1) begin errors++; $display("FAIL rst_async got sel=%b en=%b rv=%b rdy=%b want 0000/0/0/1", selectors, enable, rspValid, reqReady); end
    checks++; if ({addr, wData, strb, prot, write, rspRData, rspError} !== '0) begin errors++; $display("FAIL rst_regs got addr=%h wData=%h strb=%h prot=%h write=%b rdata=%h err=%b want all 0", addr, wData, strb, prot, write, rspRData, rspError); end
    @(negedge clk);
    nReset = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rspValid !== 1'b0 || reqReady !== 1'b1 || enable !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_after got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWData = '0; reqStrb = '0; reqProt = '0;
    rspReady = 1'b1; prphReady = '0; prphRData = '0; prphError = '0;
    r3_reqValid = 1'b0; r3_reqWrite = 1'b0; r3_reqAddr = '0; r3_reqWData = '0; r3_reqStrb = '0; r3_reqProt = '0;
    r3_rspReady = 1'b1; r3_prphReady = 3'b111; r3_prphError = 3'b000;
    r3_prphRData = {32'h00C0_FFEE, 32'h0000_0B0B, 32'h0000_0A0A};
    repeat (3) @(negedge clk);
    test_reset;
    nReset = 1'b1;
    @(negedge clk);
    test_zero_wait_write;
    test_wait_read;
    test_periph_error;
    test_decode_error;
    test_timeout;
    test_back_to_back;
    test_backpressure_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_multi_manager.md
Name: apb_multi_manager

Overview:
- Parametrised single-manager APB requester for PrphNum peripherals.
- Accepts simple valid/ready transfer requests from an upstream master and decodes the target peripheral from the address.
- Runs the APB SETUP/ACCESS sequence with per-peripheral ready, read-data and error muxing, plus an optional wait-state timeout.
- Returns a held response to the upstream side; sits between bus bridges and APB peripherals.

Parameters:
- AddrWidth, 32, bit-width of addresses.
- DataWidth, 32, bit-width of data; multiple of 8.
- PrphNum, 4, number of peripherals; at least 1.
- RegionBits, 12, log2 of bytes per peripheral region; index = addr[RegionBits +: IdxW], IdxW = max(1, $clog2(PrphNum)).
- TimeoutCycles, 16, maximum ACCESS cycles before forced error; 0 disables the timeout.

Ports:
- clk  input  1  clock
- nReset  input  1  asynchronous active-low reset
- reqValid  input  1  upstream request valid
- reqReady  output  1  manager can accept a request
- reqWrite  input  1  high write, low read
- reqAddr  input  AddrWidth  byte address
- reqWData  input  DataWidth  write data
- reqStrb  input  DataWidth/8  write strobes
- reqProt  input  3  protection attributes
- rspValid  output  1  response valid
- rspReady  input  1  upstream accepts response
- rspRData  output  DataWidth  read data; 0 for writes and errors
- rspError  output  1  transfer error (peripheral, decode or timeout)
- addr  output  AddrWidth  APB address
- prot  output  3  APB protection
- selectors  output  PrphNum  one-hot peripheral select
- enable  output  1  APB enable
- write  output  1  APB direction
- wData  output  DataWidth  APB write data
- strb  output  DataWidth/8  APB write strobes
- prphReady  input  PrphNum  per-peripheral ready
- prphRData  input  PrphNum*DataWidth  per-peripheral read data, lane i at [i*DataWidth +: DataWidth]
- prphError  input  PrphNum  per-peripheral error

Behaviour:
- Clock and reset: one clock `clk`; reset `nReset` is asynchronous and active-low.
- Reset values: state IDLE, selectors 0, enable 0, rspValid 0, rspError 0, rspRData 0, addr/wData/strb/prot/write 0. reqReady is 1 after reset.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - reqReady = 1.
  - On reqValid, register addr, write, wData, prot and strb. Strb is forced to 0 for reads.
  - If index < PrphNum, go to SETUP.
  - Otherwise (decode error) go straight to RESP with rspError = 1 and rspRData = 0. No APB cycle is issued.
- SETUP:
  - selectors = one-hot(index), enable = 0, reqReady = 0.
  - Always advances to ACCESS after 1 cycle.
- ACCESS:
  - enable = 1; selector and all APB outputs are held stable.
  - When prphReady[index] = 1:
    - Capture rspRData = (read and not prphError[index]) ? prphRData lane : 0.
    - Capture rspError = prphError[index].
    - Clear selectors and enable; go to RESP.
  - Ready and error from unselected lanes are ignored.
- Timeout (TimeoutCycles > 0):
  - Counter cleared on SETUP entry; increments each ACCESS cycle without ready.
  - When ready is still low on the TimeoutCycles-th ACCESS cycle, abort: clear selectors/enable, set rspError = 1, rspRData = 0, go to RESP.
  - Ready arriving on that same cycle wins: normal completion.
- RESP:
  - rspValid = 1; rspRData and rspError held until rspReady.
  - On the rspReady cycle go to IDLE.
  - No new request is accepted in RESP.
- Latency: with zero-wait peripheral and rspReady held high, request accepted at edge N gives SETUP in cycle N+1, ACCESS in N+2, rspValid high in N+3 for 1 cycle, and reqReady high again in N+4. Back-to-back transfers therefore take 4 cycles each.
- Index wider than PrphNum range (non-power-of-two PrphNum) counts as a decode error.
- Reset mid-transfer: all outputs return to reset values immediately and asynchronously. No response is generated for the aborted transfer.
- With PrphNum = 1 the index is still decoded: any address whose index bit is nonzero is a decode error.

Decomposition:
- Package apb_pkg holds:
  - the state enum apb_mgr_state_e {IDLE, SETUP, ACCESS, RESP};
  - the protection-bit localparams PROT_PRIV, PROT_NONSEC, PROT_INSTR;
  - the function calc_idx_width.
- One sub-module, apb_addr_decoder, takes addr and outputs index, one-hot selectors and a decodeErr flag. It is purely combinational and reused by future interconnect blocks.
- The FSM, timeout counter and response registers stay in apb_multi_manager.

Test Plan:
- Zero-wait write, PrphNum=4, RegionBits=12: addr=0x2010, wData=0xDEADBEEF, strb=0xF. Expect selectors=0100 for 2 cycles, enable high in cycle 2 only, rspValid 3 cycles after accept, rspError=0, rspRData=0.
- Read with 3 wait states from peripheral 1 (addr=0x1004, prphRData lane1=0x12345678, ready after 3 ACCESS cycles):
  - expect strb=0 and addr/selectors stable throughout ACCESS;
  - expect rspRData=0x12345678 and rspError=0.
- Peripheral error: read to peripheral 3 with prphError[3]=1 when ready. Expect rspError=1 and rspRData=0; prphError on unselected lane 0 during the transfer has no effect.
- Decode error: PrphNum=3, addr=0x3000. Expect no selector or enable activity ever and rspValid with rspError=1 on the cycle after accept.
- Timeout: TimeoutCycles=16, peripheral 0 never ready. Expect exactly 16 ACCESS cycles, then selectors=0, enable=0, rspError=1. Repeat with ready asserted on cycle 16: expect a normal response.
- Backpressure and reset:
  - hold rspReady=0 for 5 cycles; expect rspValid/rspRData stable and reqReady=0;
  - then assert nReset=0 mid-ACCESS on a new transfer; expect all outputs at reset values immediately and reqReady=1 after release.
